updown_cascade_cnt: RTL and testbench
=====================================

// Module: updown_cascade_cnt
// PURPOSE
//  Multi-digit up/down counter: DIGITS cascaded stages, each counting modulo RADIX.
//  Adds enable, direction, synchronous clear, parallel load, terminal-count and overflow flags.
//  General timebase/display counter for RK8 peripherals, e.g. BCD event counters and clock dividers.
// PARAMETERS
//  DIGITS  4   number of cascaded stages, >=1
//  RADIX   10  modulus of every stage, >=2
//  DW      clog2(RADIX)  localparam, bits per stage, not overridable
// PORTS
//  clk       in   1          clock, rising edge
//  rstn      in   1          asynchronous active-low reset
//  en        in   1          count enable
//  up        in   1          1 = count up, 0 = count down
//  clr       in   1          synchronous clear to zero
//  load      in   1          synchronous parallel load
//  load_val  in   DIGITS*DW  load value; stage i at [i*DW +: DW], stage 0 least significant
//  cnt       out  DIGITS*DW  current count, registered, same packing as load_val
//  tc        out  1          terminal count, combinational
//  ovf       out  1          wrap pulse, registered
// BEHAVIOUR
//  - Reset: rstn low -> cnt=0, ovf=0 immediately, independent of clk. Release is synchronous to the next clk.
//  - Priority per rising edge: clr > load > en. No control asserted -> cnt holds.
//  - clr: all stages become 0; ovf<=0.
//  - load: stage i <= load_val[i]. A stage value >= RADIX is clamped to RADIX-1. ovf<=0.
//  - en, up=1:
//    - Stage i increments when stages 0..i-1 all equal RADIX-1 (stage 0 always increments).
//    - A stage at RADIX-1 wraps to 0.
//  - en, up=0:
//    - Stage i decrements when stages 0..i-1 all equal 0.
//    - A stage at 0 wraps to RADIX-1.
//  - Carry/borrow chain is combinational ripple of per-stage "at extreme" flags; all stages update in the same cycle.
//  - tc = en & ~clr & ~load & (up ? all stages == RADIX-1 : all stages == 0).
//    Asserted in the cycle before the full-count wrap.
//  - ovf <= tc each edge: a 1-cycle pulse in the cycle after the wrap (cnt already 0, or max when counting down).
//  - Direction: up is sampled every edge; changing it mid-count takes effect on that edge, with no pipeline delay.
//  - Holding en=1 continuously: ovf pulses once every RADIX^DIGITS cycles.
//  - RADIX a power of two: behaves as a plain binary counter per stage; the clamp never triggers.
//  - Illegal state (stage >= RADIX, only reachable via X/upset): next enabled count treats it as the extreme and wraps.
// STRUCTURE
//  - Shared package cnt_pkg: function clog2(int); typedef-free. Also used by existing counters.
//  - Sub-module cnt_digit #(RADIX):
//    - Ports: clk, rstn, inc_en, dec_en, clr, load, ld_val, q, at_max, at_zero.
//    - One stage, including the clamp.
//  - Top: generate loop of DIGITS cnt_digit instances.
//    - Carry chain: inc_en[i] = en & up & &at_max[i-1:0]; dec_en[i] likewise from at_zero.
//    - Plus the tc/ovf logic.
// TESTING
//  - Reset: drive rstn=0 mid-count (cnt=0x0347) between clock edges.
//    -> cnt=0, ovf=0 at once; the first edge after release with en=1 gives cnt=1.
//  - DIGITS=4, RADIX=10, up, en=1 from 0 for 10000 cycles:
//    - cnt follows BCD 0000..9999, then 0000.
//    - tc high only at 9999; ovf high exactly 1 cycle, at 0000.
//  - Load 0x0999 then up 1 edge -> 0x1000 (three simultaneous carries). Down 1 edge -> 0x0999.
//  - Down from 0000 with en=1 -> tc=1 in that cycle; next cnt=9999 and ovf=1 for 1 cycle.
//  - Priority: clr=load=en=1 with load_val=0x1234 -> cnt=0.
//    Then load=en=1 with load_val=0x12F4 -> cnt=0x1294 (clamped stage), no increment.
//  - RADIX=16, DIGITS=2: en toggled randomly, up toggled randomly for 2000 cycles.
//    -> cnt matches the reference model (cnt +/- 1 mod 256); ovf matches model wraps.

Source files
------------

// File: rtl/cnt_pkg.sv
// rtl/cnt_pkg.sv - shared counter helpers
package cnt_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < v) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cnt_digit.sv
// rtl/cnt_digit.sv - one modulo-RADIX up/down stage with clamped load
module cnt_digit
    import cnt_pkg::*;
#(
    parameter int RADIX = 10,
    localparam int DW = clog2(RADIX)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inc_en,
    input  logic          dec_en,
    input  logic          clr,
    input  logic          load,
    input  logic [DW-1:0] ld_val,
    output logic [DW-1:0] q,
    output logic          at_max,
    output logic          at_zero
);

    localparam logic [DW:0]   TOP  = (DW+1)'(RADIX - 1);
    localparam logic [DW-1:0] MAXV = DW'(RADIX - 1);

    logic [DW-1:0] ld_clamped;

    // Out-of-range codes count as the extreme for both directions so they wrap out.
    assign at_max     = ({1'b0, q} >= TOP);
    assign at_zero    = (q == '0) || ({1'b0, q} > TOP);
    assign ld_clamped = ({1'b0, ld_val} > TOP) ? MAXV : ld_val;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= ld_clamped;
        end else if (inc_en) begin
            q <= at_max ? '0 : q + 1'b1;
        end else if (dec_en) begin
            q <= at_zero ? MAXV : q - 1'b1;
        end
    end

endmodule

// File: rtl/updown_cascade_cnt.sv
// rtl/updown_cascade_cnt.sv - cascaded multi-digit up/down counter with tc/ovf
module updown_cascade_cnt
    import cnt_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int RADIX  = 10,
    localparam int DW = clog2(RADIX)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 up,
    input  logic                 clr,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] cnt,
    output logic                 tc,
    output logic                 ovf
);

    logic [DIGITS-1:0] at_max;
    logic [DIGITS-1:0] at_zero;
    logic [DIGITS:0]   max_chain;
    logic [DIGITS:0]   zero_chain;

    assign max_chain[0]  = 1'b1;
    assign zero_chain[0] = 1'b1;

    // Ripple chain: stage i moves only when every lower stage sits at its extreme.
    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign max_chain[i+1]  = max_chain[i] & at_max[i];
        assign zero_chain[i+1] = zero_chain[i] & at_zero[i];

        cnt_digit #(.RADIX(RADIX)) u_digit (
            .clk     (clk),
            .rstn    (rstn),
            .inc_en  (en & up & max_chain[i]),
            .dec_en  (en & ~up & zero_chain[i]),
            .clr     (clr),
            .load    (load),
            .ld_val  (load_val[i*DW +: DW]),
            .q       (cnt[i*DW +: DW]),
            .at_max  (at_max[i]),
            .at_zero (at_zero[i])
        );
    end

    assign tc = en & ~clr & ~load & (up ? max_chain[DIGITS] : zero_chain[DIGITS]);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ovf <= 1'b0;
        end else begin
            ovf <= tc;
        end
    end

endmodule

// File: tb/tb_updown_cascade_cnt.sv
// tb/tb_updown_cascade_cnt.sv - directed checks for updown_cascade_cnt
module tb_updown_cascade_cnt;

    logic        clk;
    logic        rstn;
    logic        en, up, clr, load;
    logic [15:0] load_val;
    logic [15:0] cnt;
    logic        tc, ovf;

    logic        en2, up2, clr2, load2;
    logic [7:0]  load_val2;
    logic [7:0]  cnt2;
    logic        tc2, ovf2;

    int tests;
    int fails;

    updown_cascade_cnt #(.DIGITS(4), .RADIX(10)) dut (
        .clk(clk), .rstn(rstn), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt), .tc(tc), .ovf(ovf)
    );

    updown_cascade_cnt #(.DIGITS(2), .RADIX(16)) dut_hex (
        .clk(clk), .rstn(rstn), .en(en2), .up(up2), .clr(clr2), .load(load2),
        .load_val(load_val2), .cnt(cnt2), .tc(tc2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[3:0]   = 4'(v % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[15:12] = 4'((v / 1000) % 10);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tests++;
        if (cnt !== 16'h0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_initial: cnt=%h ovf=%b, expected cnt=0000 ovf=0", cnt, ovf);
        end
        @(negedge clk);
        rstn = 1'b1;
        step();
        load = 1'b1; load_val = 16'h0347;
        step();
        load = 1'b0; en = 1'b1; up = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        tests++;
        if (cnt !== 16'h0000 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: cnt=%h ovf=%b, expected cnt=0000 ovf=0", cnt, ovf);
        end
        @(negedge clk);
        rstn = 1'b1; up = 1'b1;
        step();
        tests++;
        if (cnt !== 16'h0001) begin
            fails++;
            $display("FAIL reset_release: cnt=%h, expected 0001", cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_bcd_sweep();
        int sweep_fails;
        logic [15:0] exp_cnt;
        sweep_fails = 0;
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1; up = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            tests++;
            if (tc !== (k == 9999)) begin
                fails++; sweep_fails++;
                if (sweep_fails < 20) $display("FAIL sweep_tc k=%0d: tc=%b, expected %b", k, tc, (k == 9999));
            end
            step();
            exp_cnt = to_bcd((k + 1) % 10000);
            tests++;
            if (cnt !== exp_cnt || ovf !== (k == 9999)) begin
                fails++; sweep_fails++;
                if (sweep_fails < 20)
                    $display("FAIL sweep_cnt k=%0d: cnt=%h ovf=%b, expected cnt=%h ovf=%b",
                             k, cnt, ovf, exp_cnt, (k == 9999));
            end
        end
        step();
        tests++;
        if (cnt !== 16'h0001 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL sweep_after: cnt=%h ovf=%b, expected cnt=0001 ovf=0", cnt, ovf);
        end
        en = 1'b0;
    endtask

    task automatic test_carry();
        load = 1'b1; load_val = 16'h0999; en = 1'b0;
        step();
        load = 1'b0;
        tests++;
        if (cnt !== 16'h0999) begin
            fails++;
            $display("FAIL carry_load: cnt=%h, expected 0999", cnt);
        end
        en = 1'b1; up = 1'b1;
        step();
        tests++;
        if (cnt !== 16'h1000) begin
            fails++;
            $display("FAIL carry_up: cnt=%h, expected 1000", cnt);
        end
        up = 1'b0;
        step();
        tests++;
        if (cnt !== 16'h0999) begin
            fails++;
            $display("FAIL borrow_down: cnt=%h, expected 0999", cnt);
        end
        en = 1'b0;
    endtask

    task automatic test_down_wrap();
        clr = 1'b1;
        step();
        clr = 1'b0; en = 1'b1; up = 1'b0;
        #1;
        tests++;
        if (tc !== 1'b1) begin
            fails++;
            $display("FAIL down_tc: tc=%b, expected 1", tc);
        end
        step();
        tests++;
        if (cnt !== 16'h9999 || ovf !== 1'b1) begin
            fails++;
            $display("FAIL down_wrap: cnt=%h ovf=%b, expected cnt=9999 ovf=1", cnt, ovf);
        end
        en = 1'b0;
        step();
        tests++;
        if (cnt !== 16'h9999 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL down_hold: cnt=%h ovf=%b, expected cnt=9999 ovf=0", cnt, ovf);
        end
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; en = 1'b1; up = 1'b1; load_val = 16'h1234;
        #1;
        tests++;
        if (tc !== 1'b0) begin
            fails++;
            $display("FAIL prio_tc: tc=%b, expected 0", tc);
        end
        step();
        tests++;
        if (cnt !== 16'h0000) begin
            fails++;
            $display("FAIL prio_clr: cnt=%h, expected 0000", cnt);
        end
        clr = 1'b0; load_val = 16'h12F4;
        step();
        tests++;
        if (cnt !== 16'h1294 || ovf !== 1'b0) begin
            fails++;
            $display("FAIL prio_load_clamp: cnt=%h ovf=%b, expected cnt=1294 ovf=0", cnt, ovf);
        end
        load = 1'b0; en = 1'b0;
        step();
        tests++;
        if (cnt !== 16'h1294) begin
            fails++;
            $display("FAIL prio_hold: cnt=%h, expected 1294", cnt);
        end
    endtask

    task automatic test_hex_random();
        int m;
        int hex_fails;
        logic exp_tc;
        m = 0;
        hex_fails = 0;
        for (int k = 0; k < 2000; k++) begin
            en2 = 1'($urandom_range(0, 1));
            up2 = 1'($urandom_range(0, 1));
            if (k < 300) en2 = 1'b1;
            if (k < 260) up2 = 1'b1;
            #1;
            exp_tc = en2 && (up2 ? (m == 255) : (m == 0));
            tests++;
            if (tc2 !== exp_tc) begin
                fails++; hex_fails++;
                if (hex_fails < 20) $display("FAIL hex_tc k=%0d: tc=%b, expected %b", k, tc2, exp_tc);
            end
            if (en2) m = up2 ? (m + 1) % 256 : (m + 255) % 256;
            step();
            tests++;
            if (cnt2 !== 8'(m) || ovf2 !== exp_tc) begin
                fails++; hex_fails++;
                if (hex_fails < 20)
                    $display("FAIL hex_cnt k=%0d: cnt=%h ovf=%b, expected cnt=%h ovf=%b",
                             k, cnt2, ovf2, 8'(m), exp_tc);
            end
        end
        en2 = 1'b0;
    endtask

    initial begin
        tests = 0; fails = 0;
        rstn = 1'b0;
        en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 16'h0000;
        en2 = 1'b0; up2 = 1'b1; clr2 = 1'b0; load2 = 1'b0; load_val2 = 8'h00;
        #3;
        test_reset();
        test_carry();
        test_down_wrap();
        test_priority();
        test_bcd_sweep();
        test_hex_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
